// File: rtl/regfile_wr_arbiter.sv
// Write-port owner for the 2R/1W register file: clears every entry after
// reset or on request, then round-robins two writeback requesters.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   init_start         one-cycle pulse requesting a full clear (RUN only)
//   wb0_* / wb1_*      valid/addr/data in, ready out (combinational grant)
//   rf_wen/rf_wr_addr/rf_wr_data  registered register-file write port
//   init_done          high while in RUN
module regfile_wr_arbiter #(
    parameter int BW_DATA  = 32,
    parameter int BW_ADDR  = 5,
    parameter int ZERO_REG = 1
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               init_start,
    input  logic               wb0_valid,
    input  logic [BW_ADDR-1:0] wb0_addr,
    input  logic [BW_DATA-1:0] wb0_data,
    output logic               wb0_ready,
    input  logic               wb1_valid,
    input  logic [BW_ADDR-1:0] wb1_addr,
    input  logic [BW_DATA-1:0] wb1_data,
    output logic               wb1_ready,
    output logic               rf_wen,
    output logic [BW_ADDR-1:0] rf_wr_addr,
    output logic [BW_DATA-1:0] rf_wr_data,
    output logic               init_done
);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [BW_ADDR-1:0] CNT_LAST = '1;

    state_t             state_q, state_d;
    logic [BW_ADDR-1:0] cnt_q, cnt_d;
    // 1: wb1 wins the next contention (wb0 was granted last)
    logic               prio1_q, prio1_d;
    logic               wen_d;
    logic [BW_ADDR-1:0] addr_d;
    logic [BW_DATA-1:0] data_d;
    logic               grant0, grant1;
    logic [BW_ADDR-1:0] sel_addr;
    logic [BW_DATA-1:0] sel_data;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= INIT;
            cnt_q      <= '0;
            prio1_q    <= 1'b0;
            rf_wen     <= 1'b0;
            rf_wr_addr <= '0;
            rf_wr_data <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            prio1_q    <= prio1_d;
            rf_wen     <= wen_d;
            rf_wr_addr <= addr_d;
            rf_wr_data <= data_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        prio1_d  = prio1_q;
        wen_d    = 1'b0;
        addr_d   = rf_wr_addr;
        data_d   = rf_wr_data;
        grant0   = 1'b0;
        grant1   = 1'b0;
        sel_addr = '0;
        sel_data = '0;

        unique case (state_q)
            INIT: begin
                // Address 0 is cleared too, even with ZERO_REG set.
                wen_d  = 1'b1;
                addr_d = cnt_q;
                data_d = '0;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (init_start) begin
                    state_d = INIT;
                end else begin
                    grant0 = wb0_valid && (!wb1_valid || !prio1_q);
                    grant1 = wb1_valid && !grant0;

                    unique case (1'b1)
                        grant0: begin
                            sel_addr = wb0_addr;
                            sel_data = wb0_data;
                        end
                        grant1: begin
                            sel_addr = wb1_addr;
                            sel_data = wb1_data;
                        end
                        default: begin
                            sel_addr = '0;
                            sel_data = '0;
                        end
                    endcase

                    if (grant0 || grant1) begin
                        // A write to x0 still completes the handshake
                        // and moves the pointer, but never reaches the file.
                        wen_d   = !((ZERO_REG != 0) && (sel_addr == '0));
                        addr_d  = sel_addr;
                        data_d  = sel_data;
                        prio1_d = grant0;
                    end
                end
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    assign wb0_ready = grant0;
    assign wb1_ready = grant1;
    assign init_done = (state_q == RUN);

endmodule
